am_argmax_search: RTL

AM_ARGMAX_SEARCH -- requirements
Module: am_argmax_search

---
 rtl/hdc_am_pkg.sv | 16 +
 rtl/am_argmax_search.sv | 111 +++++++++++
 2 files changed

// File: rtl/hdc_am_pkg.sv
// Shared definitions for the associative-memory argmax search and its accuracy tally.
// Holds the class index width, the default score width and the search FSM states.
package hdc_am_pkg;

    localparam int CLASS_W     = 5;
    localparam int SCORE_W_DEF = 10;

    typedef logic [CLASS_W-1:0] class_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } am_state_t;

endpackage

// File: rtl/am_argmax_search.sv
// Streams one similarity score per class and reports the highest-scoring class index.
// Ties keep the lowest index; results stay put until the next query's final score.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; results of the last query held
// ST_SCAN | accepting scores in class order, tracking running best
// ST_DONE | one-cycle result strobe for the accuracy tally
module am_argmax_search #(
    parameter int SCORE_W = hdc_am_pkg::SCORE_W_DEF,
    parameter int CLASS_W = hdc_am_pkg::CLASS_W
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic [CLASS_W-1:0] num_classes_m1,
    input  logic [CLASS_W-1:0] correct_class_in,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    output logic               score_ready,
    output logic               busy,
    output logic [CLASS_W-1:0] class_inference,
    output logic [SCORE_W-1:0] best_score,
    output logic [CLASS_W-1:0] correct_class,
    output logic               tallying_accuracy
);
    import hdc_am_pkg::*;

    am_state_t          state, state_nxt;
    logic [CLASS_W-1:0] idx;
    logic [CLASS_W-1:0] last_idx;
    logic [CLASS_W-1:0] label;
    logic [SCORE_W-1:0] run_best;
    logic [CLASS_W-1:0] run_idx;

    logic               accept;
    logic               take;
    logic               last;
    logic [SCORE_W-1:0] best_nxt;
    logic [CLASS_W-1:0] best_idx_nxt;

    assign accept       = (state == ST_SCAN) && score_valid;
    assign last         = (idx == last_idx);
    // Strict compare keeps the earliest class on ties.
    assign take         = (idx == '0) || (score > run_best);
    assign best_nxt     = take ? score : run_best;
    assign best_idx_nxt = take ? idx   : run_idx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        score_ready       = 1'b0;
        busy              = 1'b1;
        tallying_accuracy = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                score_ready = 1'b1;
                if (accept && last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                tallying_accuracy = 1'b1;
                state_nxt         = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx             <= '0;
            last_idx        <= '0;
            label           <= '0;
            run_best        <= '0;
            run_idx         <= '0;
            class_inference <= '0;
            best_score      <= '0;
            correct_class   <= '0;
        end else if (state == ST_IDLE && start) begin
            idx      <= '0;
            run_best <= '0;
            run_idx  <= '0;
            last_idx <= num_classes_m1;
            label    <= correct_class_in;
        end else if (accept) begin
            run_best <= best_nxt;
            run_idx  <= best_idx_nxt;
            if (last) begin
                class_inference <= best_idx_nxt;
                best_score      <= best_nxt;
                correct_class   <= label;
            end else begin
                idx <= idx + CLASS_W'(1);
            end
        end
    end

endmodule
